muldiv_seq: RTL

Iterative unsigned multiply/divide sequencer for the MIPS core. It executes `multu`/`divu` in 32 single-bit iterations on the shared 32-bit ALU instead of a dedicated multiplier or divider. It requests the ALU through a req/gnt handshake and drives the ALU operands and `alucont`. Results go into HI/LO registers that the datapath reads for `mfhi`/`mflo`.

---
 rtl/muldiv_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative unsigned multu/divu sequencer. It borrows the shared
//               ALU for 32 single-bit iterations and leaves the result in HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alucont,
    input  logic [31:0] alu_result
);

    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b1010;
    localparam logic [5:0] c_LAST    = 6'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt,   w_cnt_nxt;
    logic        r_opr,   w_opr_nxt;
    logic [31:0] r_m,     w_m_nxt;
    logic [31:0] r_hi,    w_hi_nxt;
    logic [31:0] r_lo,    w_lo_nxt;

    logic [31:0] w_sh;
    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    logic [3:0]  w_alucont;
    logic        w_alu_req;
    logic        w_b31;
    logic        w_carry;

    assign w_sh = {r_hi[30:0], r_lo[31]};

    // ALU carry-out rebuilt from MSBs; subtract adds ~m, so its MSB is inverted.
    assign w_b31   = r_opr ? ~r_m[31] : r_m[31];
    assign w_carry = (w_alu_a[31] & w_b31) | ((w_alu_a[31] | w_b31) & ~alu_result[31]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_opr   <= 1'b0;
            r_m     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_opr   <= w_opr_nxt;
            r_m     <= w_m_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_opr_nxt   = r_opr;
        w_m_nxt     = r_m;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_alu_a     = 32'd0;
        w_alu_b     = 32'd0;
        w_alucont   = 4'b0000;
        w_alu_req   = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 6'd0;
                    w_opr_nxt   = op;
                    w_m_nxt     = op ? srcb : srca;
                    w_hi_nxt    = 32'd0;
                    w_lo_nxt    = op ? srca : srcb;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_RUN: begin
                w_alu_req = 1'b1;
                w_alu_b   = r_m;
                if (r_opr) begin
                    w_alu_a   = w_sh;
                    w_alucont = c_ALU_SUB;
                end else begin
                    w_alu_a   = r_hi;
                    w_alucont = c_ALU_ADD;
                end

                if (alu_gnt) begin
                    w_cnt_nxt = r_cnt + 6'd1;
                    if (r_opr) begin
                        // Restoring step: keep the difference only when it did not borrow.
                        if (r_hi[31] | w_carry) begin
                            w_hi_nxt = alu_result;
                            w_lo_nxt = {r_lo[30:0], 1'b1};
                        end else begin
                            w_hi_nxt = w_sh;
                            w_lo_nxt = {r_lo[30:0], 1'b0};
                        end
                    end else begin
                        if (r_lo[0]) begin
                            {w_hi_nxt, w_lo_nxt} = {w_carry, alu_result, r_lo[31:1]};
                        end else begin
                            {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[31:1]};
                        end
                    end
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign alu_req = w_alu_req;
    assign alu_a   = w_alu_a;
    assign alu_b   = w_alu_b;
    assign alucont = w_alucont;

endmodule

`default_nettype wire
